isp_stream_ctrl: RTL and testbench

//  Frame/line sequencer at the front of the ISP chain. Pulls 8-bit Bayer raw

---
 rtl/isp_timing_pkg.sv | 24 ++
 rtl/isp_span_counter.sv | 35 +++
 rtl/isp_stream_ctrl.sv | 174 +++++++++++++++++
 tb/tb_isp_stream_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_timing_pkg.sv
// Shared types and constants for the ISP stream sequencer.
// States, counter width and the fixed raw codes for blanking and underflow.
package isp_timing_pkg;

  localparam int CNT_W = 12;

  localparam logic [7:0] BLANK_RAW = 8'hff;
  localparam logic [7:0] UFLOW_RAW = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VPRE   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HBLANK = 3'd3,
    ST_VPOST  = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  function automatic logic in_frame(state_e s);
    return (s == ST_VPRE) || (s == ST_ACTIVE) ||
           (s == ST_HBLANK) || (s == ST_VPOST);
  endfunction

endpackage

// File: rtl/isp_span_counter.sv
// Load/enable span counter with terminal-count flag.
// Used for cycle-in-state and line index tracking.
module isp_span_counter
  import isp_timing_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (en)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign count = cnt_q;
  assign tc    = (cnt_q == last);

endmodule

// File: rtl/isp_stream_ctrl.sv
// Frame/line sequencer producing vsync/hsync/den over upstream raw.
// ISP_STREAM_TPG_EN adds tpg_sel and an internal (x+y) test pattern.
module isp_stream_ctrl
  import isp_timing_pkg::*;
#(
  parameter int H_ACTIVE  = 512,
  parameter int V_ACTIVE  = 512,
  parameter int H_BLANK   = 16,
  parameter int V_PRE     = 4,
  parameter int V_POST    = 4,
  parameter int FRAME_GAP = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       src_valid,
  input  logic [7:0] src_data,
`ifdef ISP_STREAM_TPG_EN
  input  logic       tpg_sel,
`endif
  output logic       src_ready,
  output logic       out_vsync,
  output logic       out_hsync,
  output logic       out_den,
  output logic [7:0] out_raw,
  output logic       busy,
  output logic       frame_done,
  output logic       underflow
);

  if (H_BLANK < 1 || FRAME_GAP < 1) begin : g_bad_param
    $error("isp_stream_ctrl: H_BLANK and FRAME_GAP must be >= 1");
  end

  localparam logic [CNT_W-1:0] HA_L = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VA_L = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HB_L = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] VP_L = CNT_W'(V_PRE - 1);
  localparam logic [CNT_W-1:0] VO_L = CNT_W'(V_POST - 1);
  localparam logic [CNT_W-1:0] FG_L = CNT_W'(FRAME_GAP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_cnt, line_cnt, cyc_last;
  logic             cyc_tc, line_tc;
  logic             accept, tpg_on, unused_cnt;
  logic [7:0]       tpg_pix;

  logic       vsync_q, vsync_d;
  logic       den_q, den_d;
  logic [7:0] raw_q, raw_d;
  logic       busy_q, busy_d;
  logic       fdone_q, fdone_d;
  logic       uflow_q, uflow_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_VPRE;
      ST_VPRE:   if (cyc_tc) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cyc_tc) state_d = ST_HBLANK;
      ST_HBLANK: if (cyc_tc) state_d = line_tc ? ST_VPOST : ST_ACTIVE;
      ST_VPOST:  if (cyc_tc) state_d = ST_GAP;
      ST_GAP:    if (cyc_tc) state_d = continuous ? ST_VPRE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_last = '0;
    unique case (state_q)
      ST_VPRE:   cyc_last = VP_L;
      ST_ACTIVE: cyc_last = HA_L;
      ST_HBLANK: cyc_last = HB_L;
      ST_VPOST:  cyc_last = VO_L;
      ST_GAP:    cyc_last = FG_L;
      default:   cyc_last = '0;
    endcase
  end

  isp_span_counter u_cyc (
    .clk     (clk),
    .reset_n (reset_n),
    .load    ((state_d != state_q) || (state_q == ST_IDLE)),
    .en      (1'b1),
    .last    (cyc_last),
    .count   (cyc_cnt),
    .tc      (cyc_tc)
  );

  // Line index is re-zeroed throughout VPRE, so every frame starts at line 0.
  isp_span_counter u_line (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state_q == ST_VPRE),
    .en      ((state_q == ST_HBLANK) && cyc_tc),
    .last    (VA_L),
    .count   (line_cnt),
    .tc      (line_tc)
  );

`ifdef ISP_STREAM_TPG_EN
  logic tpg_q, tpg_d;

  always_comb begin
    tpg_d = tpg_q;
    if (state_d == ST_VPRE && state_q != ST_VPRE)
      tpg_d = tpg_sel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      tpg_q <= 1'b0;
    else
      tpg_q <= tpg_d;
  end

  assign tpg_on     = tpg_q;
  assign tpg_pix    = cyc_cnt[7:0] + line_cnt[7:0];
  assign unused_cnt = ^{cyc_cnt[CNT_W-1:8], line_cnt[CNT_W-1:8]};
`else
  assign tpg_on     = 1'b0;
  assign tpg_pix    = '0;
  assign unused_cnt = ^{cyc_cnt, line_cnt};
`endif

  assign accept = (state_q == ST_ACTIVE);

  always_comb begin
    vsync_d = in_frame(state_d);
    busy_d  = (state_d != ST_IDLE);
    fdone_d = vsync_q && !vsync_d;
    den_d   = accept;
    raw_d   = BLANK_RAW;
    uflow_d = uflow_q;
    if (accept)
      raw_d = tpg_on    ? tpg_pix  :
              src_valid ? src_data : UFLOW_RAW;
    if (state_q == ST_IDLE && start)
      uflow_d = 1'b0;
    else if (accept && !tpg_on && !src_valid)
      uflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      vsync_q <= 1'b0;
      den_q   <= 1'b0;
      raw_q   <= BLANK_RAW;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_d;
      den_q   <= den_d;
      raw_q   <= raw_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      uflow_q <= uflow_d;
    end
  end

  assign src_ready  = accept && !tpg_on;
  assign out_vsync  = vsync_q;
  assign out_hsync  = den_q;
  assign out_den    = den_q;
  assign out_raw    = raw_q;
  assign busy       = busy_q;
  assign frame_done = fdone_q;
  assign underflow  = uflow_q;

endmodule

// File: tb/tb_isp_stream_ctrl.sv
// Self-checking bench for isp_stream_ctrl against a frame-position model.
// Define ISP_STREAM_TPG_EN to also exercise the test pattern path.
module tb_isp_stream_ctrl;

  localparam int HA   = 8;
  localparam int VA   = 4;
  localparam int HB   = 2;
  localparam int VP   = 3;
  localparam int VO   = 3;
  localparam int FG   = 5;
  localparam int LINE = HA + HB;
  localparam int FLEN = VP + VA * LINE + VO;
  localparam int PER  = FLEN + FG;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       src_valid = 1'b0;
  logic [7:0] src_data = 8'h00;
`ifdef ISP_STREAM_TPG_EN
  logic       tpg_sel = 1'b0;
`endif
  logic       src_ready, out_vsync, out_hsync, out_den;
  logic [7:0] out_raw;
  logic       busy, frame_done, underflow;

  isp_stream_ctrl #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .V_PRE(VP), .V_POST(VO), .FRAME_GAP(FG)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .continuous (continuous),
    .src_valid  (src_valid),
    .src_data   (src_data),
`ifdef ISP_STREAM_TPG_EN
    .tpg_sel    (tpg_sel),
`endif
    .src_ready  (src_ready),
    .out_vsync  (out_vsync),
    .out_hsync  (out_hsync),
    .out_den    (out_den),
    .out_raw    (out_raw),
    .busy       (busy),
    .frame_done (frame_done),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: m_t = cycles since vsync rise (-1 when idle).
  int         m_t = -1;
  bit         m_uflow = 0;
  bit         m_tpg = 0;
  int         m_frames = 0;
  logic       e_den = 1'b0;
  logic [7:0] e_raw = 8'hff;
  int         ramp = 0;

  int         cyc_n = 0;
  int         vs_run = 0, lo_run = 0, fd_cnt = 0, rdy_cnt = 0;
  int         vs_fall_at = 0, busy_fall_at = 0;
  bit         seen_hi = 0, vs_prev = 0, busy_prev = 0;
  int         vs_hi_q[$];
  int         vs_lo_q[$];
  logic [7:0] raw_q[$];

  function automatic bit slot(int t);
    int a;
    a = t - VP;
    return (t >= 0) && (a < VA * LINE) && ((a % LINE) < HA) && (a >= 0);
  endfunction

  function automatic bit sel_tpg();
`ifdef ISP_STREAM_TPG_EN
    return tpg_sel;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0d", tag, obs, exp, m_t);
    end
  endtask

  task automatic chk8(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, m_t);
    end
  endtask

  task automatic chki(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    vs_hi_q.delete();
    vs_lo_q.delete();
    raw_q.delete();
    fd_cnt  = 0;
    rdy_cnt = 0;
    seen_hi = 0;
    vs_run  = 0;
    lo_run  = 0;
  endtask

  task automatic cyc();
    int a;
    chk1("src_ready", src_ready, slot(m_t) && !m_tpg);
    if (src_ready) rdy_cnt++;
    if (slot(m_t) && !m_tpg && !src_valid) m_uflow = 1;
    if (slot(m_t) && !m_tpg) ramp++;
    a     = m_t - VP;
    e_den = slot(m_t);
    if (!e_den)     e_raw = 8'hff;
    else if (m_tpg) e_raw = 8'((a % LINE) + (a / LINE));
    else            e_raw = src_valid ? src_data : 8'h00;
    if (m_t < 0) begin
      if (start) begin
        m_t = 0; m_uflow = 0; m_tpg = sel_tpg(); m_frames++;
      end
    end else if (m_t == PER - 1) begin
      if (continuous) begin
        m_t = 0; m_tpg = sel_tpg(); m_frames++;
      end else m_t = -1;
    end else m_t++;
    @(posedge clk);
    #1;
    chk1("vsync", out_vsync, (m_t >= 0) && (m_t < FLEN));
    chk1("hsync", out_hsync, e_den);
    chk1("den", out_den, e_den);
    chk8("raw", out_raw, e_raw);
    chk1("busy", busy, m_t >= 0);
    chk1("frame_done", frame_done, m_t == FLEN);
    chk1("underflow", underflow, m_uflow);
    cyc_n++;
    if (out_vsync) begin
      if (!vs_prev && seen_hi) vs_lo_q.push_back(lo_run);
      vs_run++;
    end else begin
      if (vs_prev) begin
        vs_hi_q.push_back(vs_run);
        vs_run = 0; seen_hi = 1; lo_run = 0; vs_fall_at = cyc_n;
      end
      lo_run++;
    end
    if (busy_prev && !busy) busy_fall_at = cyc_n;
    if (frame_done) fd_cnt++;
    if (out_den) raw_q.push_back(out_raw);
    vs_prev   = out_vsync;
    busy_prev = busy;
  endtask

  task automatic chk_reset_vals(string tag);
    chk1({tag, "_vsync"}, out_vsync, 1'b0);
    chk1({tag, "_hsync"}, out_hsync, 1'b0);
    chk1({tag, "_den"}, out_den, 1'b0);
    chk8({tag, "_raw"}, out_raw, 8'hff);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_fdone"}, frame_done, 1'b0);
    chk1({tag, "_uflow"}, underflow, 1'b0);
    chk1({tag, "_ready"}, src_ready, 1'b0);
  endtask

  initial begin
    int f0;
    // Power-on reset
    @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset_n = 1'b1;
    repeat (2) cyc();

    // 1: single frame, ramp data
    clr();
    ramp = 0;
    src_valid = 1'b1;
    for (int i = 0; i < PER + 3; i++) begin
      start = (i == 0);
      src_data = 8'(ramp);
      cyc();
    end
    start = 1'b0;
    chki("t1_pixels", raw_q.size(), VA * HA);
    for (int i = 0; i < VA * HA && i < raw_q.size(); i++)
      chk8("t1_ramp", raw_q[i], 8'(i));
    chki("t1_frames", vs_hi_q.size(), 1);
    if (vs_hi_q.size() > 0) chki("t1_vs_len", vs_hi_q[0], FLEN);
    chki("t1_fdone", fd_cnt, 1);
    chki("t1_busy_lag", busy_fall_at - vs_fall_at, FG);

    // 2: missing pixel 3 of line 1
    clr();
    for (int i = 0; i < PER + 3; i++) begin
      start = (i == 0);
      src_data = 8'($urandom);
      src_valid = !(m_t == VP + LINE + 3);
      cyc();
    end
    start = 1'b0;
    src_valid = 1'b1;
    chki("t2_pixels", raw_q.size(), VA * HA);
    if (raw_q.size() > HA + 3) chk8("t2_uflow_raw", raw_q[HA + 3], 8'h00);
    chk1("t2_uflow_sticky", underflow, 1'b1);
    if (vs_hi_q.size() > 0) chki("t2_vs_len", vs_hi_q[0], FLEN);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk1("t2_uflow_clear", underflow, 1'b0);
    for (int i = 0; i < PER + 2; i++) cyc();

    // 3: continuous, three frames, random valid
    clr();
    f0 = m_frames;
    for (int i = 0; i < 3 * PER + 5; i++) begin
      start = (i == 0);
      continuous = (m_frames - f0 < 3);
      src_valid = ($urandom_range(0, 9) != 0);
      src_data = 8'($urandom);
      cyc();
    end
    start = 1'b0;
    continuous = 1'b0;
    src_valid = 1'b1;
    chki("t3_fdone", fd_cnt, 3);
    chki("t3_frames", vs_hi_q.size(), 3);
    foreach (vs_hi_q[k]) chki("t3_vs_len", vs_hi_q[k], FLEN);
    chki("t3_gaps", vs_lo_q.size(), 2);
    foreach (vs_lo_q[k]) chki("t3_gap_len", vs_lo_q[k], FG);

    // 4: async reset during line 2
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 200 && m_t != VP + 2 * LINE + 3; i++) begin
      src_data = 8'($urandom);
      cyc();
    end
    chki("t4_reached_line2", m_t, VP + 2 * LINE + 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("t4_rst");
    m_t = -1; m_uflow = 0; e_den = 0;
    vs_prev = 0; busy_prev = 0;
    #2;
    reset_n = 1'b1;
    repeat (3) cyc();
    clr();
    for (int i = 0; i < PER + 3; i++) begin
      start = (i == 0);
      src_data = 8'($urandom);
      cyc();
    end
    start = 1'b0;
    chki("t4_frames", vs_hi_q.size(), 1);
    if (vs_hi_q.size() > 0) chki("t4_vs_len", vs_hi_q[0], FLEN);
    chki("t4_pixels", raw_q.size(), VA * HA);

    // 5: start held while busy
    clr();
    for (int i = 0; i < PER + 6; i++) begin
      start = (i == 0) || (m_t >= 0);
      src_data = 8'($urandom);
      cyc();
    end
    start = 1'b0;
    chki("t5_frames", vs_hi_q.size(), 1);
    chki("t5_fdone", fd_cnt, 1);
    if (vs_hi_q.size() > 0) chki("t5_vs_len", vs_hi_q[0], FLEN);

`ifdef ISP_STREAM_TPG_EN
    // 6: test pattern
    clr();
    tpg_sel = 1'b1;
    for (int i = 0; i < PER + 3; i++) begin
      start = (i == 0);
      src_valid = $urandom_range(0, 1) != 0;
      src_data = 8'($urandom);
      cyc();
    end
    start = 1'b0;
    tpg_sel = 1'b0;
    src_valid = 1'b1;
    chki("t6_ready_cnt", rdy_cnt, 0);
    chki("t6_pixels", raw_q.size(), VA * HA);
    for (int i = 0; i < HA && 2 * HA + i < raw_q.size(); i++)
      chk8("t6_line2", raw_q[2 * HA + i], 8'(2 + i));
    chk1("t6_no_uflow", underflow, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
